// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, parameter defaults and FSM encoding for the MAC sequencer
package mac_pkg;
    localparam int DP_SUM_W      = 20;
    localparam int LANES         = 16;
    localparam int PIX_W         = 8;
    localparam int IDX_W         = 10;
    localparam int N_CHUNKS_DEF  = 49;
    localparam int N_NEURONS_DEF = 32;
    localparam int ACC_W_DEF     = 26;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;
endpackage

// File: rtl/lat_pipe.sv
// lat_pipe: resettable shift register carrying per-chunk tags through memory and datapath latency
module lat_pipe #(
    parameter int DEPTH = 2,
    parameter int W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s [DEPTH];
    // shift one stage per cycle; reset drops every in-flight tag
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int i = 0; i < DEPTH; i++) s[i] <= '0;
        else begin
            s[0] <= d;
            for (int i = 1; i < DEPTH; i++) s[i] <= s[i-1];
        end
    assign q = s[DEPTH-1];
endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: streams pixel/weight chunks into the dot-product datapath and accumulates one total per neuron
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int N_CHUNKS  = N_CHUNKS_DEF,
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int MEM_LAT   = 1,
    parameter int DP_LAT    = 1,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int PADDR_W   = 6,
    parameter int WADDR_W   = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_en,
    output logic [PADDR_W-1:0]  pix_addr,
    output logic [WADDR_W-1:0]  wgt_addr,
    input  logic [DP_SUM_W-1:0] dp_sum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_data,
    output logic [IDX_W-1:0]    out_idx
);
    localparam int L = MEM_LAT + DP_LAT;
    state_t           state;
    logic [IDX_W-1:0] n;
    logic [ACC_W-1:0] acc, sum_ext, total;
    logic             last_c, tail_v, tail_f, tail_l;
    assign last_c  = pix_addr == PADDR_W'(N_CHUNKS - 1);
    assign busy    = state != IDLE;
    assign sum_ext = ACC_W'(dp_sum);
    assign total   = tail_f ? sum_ext : acc + sum_ext;
    lat_pipe #(.DEPTH(L), .W(3)) u_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({mem_en, pix_addr == '0, last_c}),
        .q     ({tail_v, tail_f, tail_l})
    );
    // control FSM: issue chunks back to back, drain the latency, then hold the result until accepted
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            pix_addr  <= '0;
            wgt_addr  <= '0;
            n         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tail_v) acc <= total;
            case (state)
                IDLE: if (start && !done) begin
                    state    <= ISSUE;
                    mem_en   <= 1'b1;
                    pix_addr <= '0;
                    wgt_addr <= '0;
                    n        <= '0;
                end
                ISSUE: begin
                    wgt_addr <= wgt_addr + WADDR_W'(1);
                    pix_addr <= last_c ? '0 : pix_addr + PADDR_W'(1);
                    if (last_c) begin
                        state  <= DRAIN;
                        mem_en <= 1'b0;
                    end
                end
                DRAIN: if (tail_v && tail_l) begin
                    state     <= OUTPUT;
                    out_valid <= 1'b1;
                    out_data  <= total;
                    out_idx   <= n;
                end
                OUTPUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (n == IDX_W'(N_NEURONS - 1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end else begin
                        state  <= ISSUE;
                        mem_en <= 1'b1;
                        n      <= n + IDX_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: drives two sequencer configurations against behavioural RAM and dot16 models
module tb_mac_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    logic start_a = 1'b0, out_ready_a = 1'b0, start_b = 1'b0, out_ready_b = 1'b0;
    logic busy_a, done_a, mem_en_a, out_valid_a, busy_b, done_b, mem_en_b, out_valid_b;
    logic [5:0] pix_addr_a;
    logic [10:0] wgt_addr_a;
    logic [0:0] pix_addr_b;
    logic [1:0] wgt_addr_b;
    logic [19:0] dp_sum_a, dp_sum_b;
    logic [25:0] out_data_a;
    logic [19:0] out_data_b;
    logic [9:0] out_idx_a, out_idx_b;
    logic [127:0] pix_a [49], wgt_a [98], pix_b [1], wgt_b [3];
    logic [19:0] dla [2];
    logic [19:0] dlb [5];
    int checks = 0, errors = 0;

    typedef struct {
        int mode;
        int stall;
        bit poke;
        int rst_at;
        int e0;
        int e1;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    mac_sequencer #(.N_CHUNKS(49), .N_NEURONS(2), .MEM_LAT(1), .DP_LAT(1), .ACC_W(26), .PADDR_W(6), .WADDR_W(11)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .mem_en(mem_en_a),
        .pix_addr(pix_addr_a), .wgt_addr(wgt_addr_a), .dp_sum(dp_sum_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_idx(out_idx_a)
    );

    mac_sequencer #(.N_CHUNKS(1), .N_NEURONS(3), .MEM_LAT(2), .DP_LAT(3), .ACC_W(20), .PADDR_W(1), .WADDR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .mem_en(mem_en_b),
        .pix_addr(pix_addr_b), .wgt_addr(wgt_addr_b), .dp_sum(dp_sum_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_idx(out_idx_b)
    );

    function automatic int dot(input logic [127:0] p, input logic [127:0] w);
        int s = 0;
        for (int l = 0; l < 16; l++) s += int'(p[8*l +: 8]) * int'(w[8*l +: 8]);
        return s;
    endfunction

    function automatic int model_a(input int n);
        int s = 0;
        for (int c = 0; c < 49; c++) s += dot(pix_a[c], wgt_a[n*49 + c]);
        return s;
    endfunction

    // RAM latency plus datapath latency as one delay of the chunk dot product; idle slots carry junk
    always @(posedge clk) begin
        dla[0] <= (mem_en_a && pix_addr_a < 49 && wgt_addr_a < 98) ? 20'(dot(pix_a[pix_addr_a], wgt_a[wgt_addr_a])) : 20'($urandom);
        dla[1] <= dla[0];
        dlb[0] <= (mem_en_b && pix_addr_b == 0 && wgt_addr_b < 3) ? 20'(dot(pix_b[0], wgt_b[wgt_addr_b])) : 20'($urandom);
        for (int i = 1; i < 5; i++) dlb[i] <= dlb[i-1];
    end
    assign dp_sum_a = dla[1];
    assign dp_sum_b = dlb[4];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill_a(input int mode);
        logic [7:0] b;
        for (int c = 0; c < 49; c++) begin
            b = mode == 1 ? 8'd255 : 8'd1;
            pix_a[c] = mode == 3 ? {$urandom, $urandom, $urandom, $urandom} : {16{b}};
        end
        for (int a = 0; a < 98; a++) begin
            b = mode == 1 ? 8'd255 : mode == 2 ? 8'(a / 49) : 8'd1;
            wgt_a[a] = mode == 3 ? {$urandom, $urandom, $urandom, $urandom} : {16{b}};
        end
    endtask

    task automatic run_a(input int stall, input bit poke, input int rst_at, input int e0, input int e1);
        int k, n, ec, vcnt;
        bit hs, fin;
        logic [25:0] hd;
        logic [9:0] hi;
        k = 0; n = 0; ec = 0; vcnt = 0; hs = 0; fin = 0; hd = '0; hi = '0;
        start_a = 1'b1;
        while (!fin && k < 3000) begin
            @(negedge clk);
            k++;
            start_a = poke && k == 10;
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("async_reset", {busy_a, done_a, mem_en_a, pix_addr_a, wgt_addr_a, out_valid_a, out_data_a, out_idx_a}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (hs) begin
                hs = 0; n++; ec = 0; vcnt = 0;
                chk("valid_drop", out_valid_a, 0);
                if (n == 2) begin
                    chk("done_pulse", done_a, 1);
                    chk("busy_at_done", busy_a, 0);
                    fin = 1;
                    start_a = poke;
                end else chk("next_issue", mem_en_a, 1);
            end
            if (!fin) chk("busy", busy_a, 1);
            if (mem_en_a) begin
                chk("pix_addr", pix_addr_a, ec);
                chk("wgt_addr", wgt_addr_a, n*49 + ec);
                ec++;
            end
            if (out_valid_a) begin
                chk("no_issue_in_output", mem_en_a, 0);
                if (vcnt == 0) begin
                    chk("out_data", out_data_a, n == 0 ? e0 : e1);
                    chk("out_idx", out_idx_a, n);
                    chk("chunks_issued", ec, 49);
                    if (n == 0) chk("first_valid_cycle", k, 52);
                    hd = out_data_a;
                    hi = out_idx_a;
                end else begin
                    chk("hold_data", out_data_a, hd);
                    chk("hold_idx", out_idx_a, hi);
                end
                vcnt++;
                out_ready_a = vcnt > stall;
                hs = out_ready_a;
            end else out_ready_a = 1'b0;
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL timeout_a: got no done after %0d cycles", k);
        end
        @(negedge clk);
        start_a = 1'b0;
        chk("done_one_pulse", done_a, 0);
        chk("start_ignored", busy_a, 0);
    endtask

    task automatic run_b();
        int k, n;
        k = 0; n = 0;
        for (int i = 0; i < 16; i++) begin
            pix_b[0][8*i +: 8] = 8'($urandom);
            for (int j = 0; j < 3; j++) wgt_b[j][8*i +: 8] = 8'($urandom);
        end
        start_b = 1'b1;
        out_ready_b = 1'b1;
        while (n < 3 && k < 200) begin
            @(negedge clk);
            k++;
            start_b = 1'b0;
            if (out_valid_b) begin
                chk("b_out_data", out_data_b, dot(pix_b[0], wgt_b[n]));
                chk("b_out_idx", out_idx_b, n);
                if (n == 0) chk("b_first_valid_cycle", k, 7);
                n++;
            end
        end
        if (n < 3) begin
            checks++; errors++;
            $display("FAIL timeout_b: got %0d results expected 3", n);
        end
        @(negedge clk);
        chk("b_done", done_b, 1);
        chk("b_busy", busy_b, 0);
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{0, 0, 1'b0, 0, 784, 784};
        tbl[1] = '{1, 0, 1'b0, 0, 50979600, 50979600};
        tbl[2] = '{2, 0, 1'b0, 0, 0, 784};
        tbl[3] = '{3, 10, 1'b0, 0, -1, -1};
        tbl[4] = '{3, 0, 1'b1, 0, -1, -1};
        tbl[5] = '{3, 0, 1'b0, 21, -1, -1};
        tbl[6] = '{3, 0, 1'b0, 0, -1, -1};
        tbl[7] = '{3, 3, 1'b1, 0, -1, -1};
        #2;
        chk("reset_a", {busy_a, done_a, mem_en_a, pix_addr_a, wgt_addr_a, out_valid_a, out_data_a, out_idx_a}, 0);
        chk("reset_b", {busy_b, done_b, mem_en_b, pix_addr_b, wgt_addr_b, out_valid_b, out_data_b, out_idx_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int v = 0; v < 8; v++) begin
            fill_a(tbl[v].mode);
            run_a(tbl[v].stall, tbl[v].poke, tbl[v].rst_at,
                  tbl[v].e0 < 0 ? model_a(0) : tbl[v].e0,
                  tbl[v].e1 < 0 ? model_a(1) : tbl[v].e1);
        end
        for (int r = 0; r < 3; r++) run_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
